// File: rtl/input_cond_pkg.sv
// ============================================================================
// Module   : input_cond_pkg
// Brief    : Shared types and constants for the input_conditioner front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_cond_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } dbnc_state_t;

  localparam int IC_NUM_CH = 3;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module   : debounce_channel
// Brief    : One raw pin -> synchroniser chain -> counter-qualified debouncer.
//            Rise/fall strobes exist only when INPUT_COND_EDGE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  dbnc_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  // Plain flop chain: nothing may sit between synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Terminal compare is checked before the increment, so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    case (state_q)
      STABLE: begin
        if (s != level_q) begin
          state_d = CHANGING;
          cnt_d   = CNT_W'(1);
        end
      end
      CHANGING: begin
        if (s == level_q) begin
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          level_d = s;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign level_o = level_q;

`ifdef INPUT_COND_EDGE_EN
  logic rise_q, fall_q;

  // Strobes register alongside level_q so they coincide with the level edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module   : input_conditioner
// Brief    : Synchronises and debounces raw pins a/b/c for the test_2 block.
//            Optional rise/fall strobes enabled by INPUT_COND_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 raw_a,
  input  logic                 raw_b,
  input  logic                 raw_c,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic [IC_NUM_CH-1:0] rise,
  output logic [IC_NUM_CH-1:0] fall
);

  logic [IC_NUM_CH-1:0] w_raw;
  logic [IC_NUM_CH-1:0] w_level;

  assign w_raw = {raw_c, raw_b, raw_a};

  for (genvar i = 0; i < IC_NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (w_raw[i]),
      .level_o (w_level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign a = w_level[0];
  assign b = w_level[1];
  assign c = w_level[2];

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Directed-vector bench for input_conditioner (DEBOUNCE=4, SYNC=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_a = 1'b1;
  logic       raw_b = 1'b1;
  logic       raw_c = 1'b1;
  logic       a, b, c;
  logic [2:0] rise, fall;

  int n_cmp = 0;
  int n_err = 0;
  int fall_cnt;
  logic [2:0] exp_f;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS),
    .RESET_LEVEL     (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .raw_c (raw_c),
    .a     (a),
    .b     (b),
    .c     (c),
    .rise  (rise),
    .fall  (fall)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobes are only expected when the edge feature is compiled in.
  function automatic logic [2:0] strb(input logic [2:0] v);
`ifdef INPUT_COND_EDGE_EN
    return v;
`else
    return 3'b000 & v;
`endif
  endfunction

  initial begin
    // Reset with raws high
    #12;
    check_val("rst_lvl", {c, b, a}, 3'b111);
    check_val("rst_strb", {rise, fall}, 6'b0);
    tick(2);
    check_val("rst_lvl_hold", {c, b, a}, 3'b111);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("rel_strb", {rise, fall}, 6'b0);
    end
    check_val("rel_lvl", {c, b, a}, 3'b111);

    // Clean fall on channel a: 6 edges of latency
    raw_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("cf_wait_a", a, 1'b1);
    end
    tick();
    check_val("cf_lvl", {c, b, a}, 3'b110);
    check_val("cf_fall", fall, strb(3'b001));
    check_val("cf_rise", rise, 3'b000);
    tick();
    check_val("cf_fall_end", fall, 3'b000);
    check_val("cf_lvl_hold", {c, b, a}, 3'b110);
    tick(3);
    raw_a = 1'b1;
    tick(10);
    check_val("cf_restore", {c, b, a}, 3'b111);

    // Glitch on b: 3 cycles rejected
    raw_b = 1'b0;
    tick(3);
    raw_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("gl3_b", b, 1'b1);
      check_val("gl3_strb", {rise, fall}, 6'b0);
    end

    // Glitch on b: 4 cycles accepted, then recovers high
    raw_b = 1'b0;
    tick(4);
    raw_b = 1'b1;
    tick();
    check_val("gl4_wait_b", b, 1'b1);
    tick();
    check_val("gl4_fall_b", b, 1'b0);
    check_val("gl4_fall", fall, strb(3'b010));
    tick(3);
    check_val("gl4_low_b", b, 1'b0);
    check_val("gl4_nostrb", {rise, fall}, 6'b0);
    tick();
    check_val("gl4_rise_b", b, 1'b1);
    check_val("gl4_rise", rise, strb(3'b010));
    tick(4);

    // Bounce on c: 2-cycle toggles, then settle low
    fall_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      raw_c = ((k / 2) % 2) != 0;
      tick();
      if (fall[2]) fall_cnt++;
      check_val("bn_c_hi", c, 1'b1);
    end
    raw_c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (fall[2]) fall_cnt++;
      check_val("bn_settle_c", c, 1'b1);
    end
    tick();
    if (fall[2]) fall_cnt++;
    check_val("bn_c_lo", {c, b, a}, 3'b011);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (fall[2]) fall_cnt++;
    end
    exp_f = strb(3'b100);
    check_val("bn_fall_cnt", fall_cnt, {31'b0, exp_f[2]});
    raw_c = 1'b1;
    tick(10);
    check_val("bn_restore", {c, b, a}, 3'b111);

    // Simultaneous change on all channels
    {raw_c, raw_b, raw_a} = 3'b000;
    tick(5);
    check_val("sim_wait", {c, b, a}, 3'b111);
    tick();
    check_val("sim_lvl_lo", {c, b, a}, 3'b000);
    check_val("sim_fall", fall, strb(3'b111));
    tick();
    check_val("sim_fall_end", fall, 3'b000);
    {raw_c, raw_b, raw_a} = 3'b111;
    tick(6);
    check_val("sim_lvl_hi", {c, b, a}, 3'b111);
    check_val("sim_rise", rise, strb(3'b111));
    tick(4);

    // Reset while channel a is CHANGING with cnt=2
    raw_a = 1'b0;
    tick(4);
    check_val("mid_state", u_dut.g_ch[0].u_chan.state_q, 1'b1);
    check_val("mid_cnt", u_dut.g_ch[0].u_chan.cnt_q, 2'd2);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_a", a, 1'b1);
    check_val("mid_rst_cnt", u_dut.g_ch[0].u_chan.cnt_q, 2'd0);
    check_val("mid_rst_state", u_dut.g_ch[0].u_chan.state_q, 1'b0);
    check_val("mid_rst_strb", {rise, fall}, 6'b0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("mid_rel_a", a, 1'b1);
      check_val("mid_rel_strb", {rise, fall}, 6'b0);
    end
    tick();
    check_val("mid_rel_fall_a", {c, b, a}, 3'b110);
    check_val("mid_rel_fall", fall, strb(3'b001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
